// File: rtl/fp_norm_round_seq.sv
// rtl/fp_norm_round_seq.sv - normalise and round-to-nearest-even stage for the FP multiplier
// Multi-cycle normaliser (one shift per cycle) followed by a single rounding/range-check cycle.
module fp_norm_round_seq #(
  parameter  int MW = 23,
  parameter  int EW = 8,
  localparam int PW = 2*(MW+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_frac,
  input  logic [EW+1:0] in_exp,
  input  logic          in_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-1:0] out_frac,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  localparam logic signed [EW+1:0] EXP_ONE = (EW+2)'(1);
  localparam logic signed [EW+1:0] EMAX_S  = (EW+2)'((1 << EW) - 1);

  state_t                 state_q;
  logic [PW-1:0]          frac_q;
  logic signed [EW+1:0]   exp_q;
  logic                   sign_q;
  logic                   sticky_q;

  logic                   out_valid_q;
  logic                   out_sign_q;
  logic [EW-1:0]          out_exp_q;
  logic [MW-1:0]          out_frac_q;
  logic                   ovf_q;
  logic                   unf_q;

  logic [MW-1:0]          mant;
  logic                   guard;
  logic                   sticky_all;
  logic                   round_up;
  logic [MW:0]            mant_sum;
  logic signed [EW+1:0]   exp_rnd;
  logic [EW-1:0]          exp_d;
  logic [MW-1:0]          frac_d;
  logic                   ovf_d;
  logic                   unf_d;

  // Rounding and range check operate on the already-normalised value (hidden bit at PW-2).
  always_comb begin
    mant       = frac_q[PW-3 -: MW];
    guard      = frac_q[PW-3-MW];
    sticky_all = (|frac_q[PW-4-MW:0]) | sticky_q;
    round_up   = guard & (sticky_all | mant[0]);
    mant_sum   = {1'b0, mant} + {{MW{1'b0}}, round_up};
    exp_rnd    = mant_sum[MW] ? (exp_q + EXP_ONE) : exp_q;
    exp_d      = '0;
    frac_d     = '0;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    if (exp_rnd >= EMAX_S) begin
      exp_d = '1;
      ovf_d = 1'b1;
    end else if (exp_rnd[EW+1] || (exp_rnd == '0)) begin
      unf_d = 1'b1;
    end else begin
      exp_d  = exp_rnd[EW-1:0];
      frac_d = mant_sum[MW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frac_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            frac_q   <= in_frac;
            exp_q    <= in_exp;
            sign_q   <= in_sign;
            sticky_q <= 1'b0;
            state_q  <= NORM;
          end
        end
        NORM: begin
          if (frac_q[PW-1]) begin
            frac_q   <= frac_q >> 1;
            sticky_q <= sticky_q | frac_q[0];
            exp_q    <= exp_q + EXP_ONE;
            state_q  <= ROUND;
          end else if (frac_q[PW-2]) begin
            state_q <= ROUND;
          end else if (frac_q == '0) begin
            out_sign_q  <= sign_q;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            frac_q <= frac_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end
        end
        ROUND: begin
          out_sign_q  <= sign_q;
          out_exp_q   <= exp_d;
          out_frac_q  <= frac_d;
          ovf_q       <= ovf_d;
          unf_q       <= unf_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// tb/tb_fp_norm_round_seq.sv - directed bench for fp_norm_round_seq
module tb_fp_norm_round_seq;
  localparam int MW = 23;
  localparam int EW = 8;
  localparam int PW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_frac = '0;
  logic [EW+1:0] in_exp = '0;
  logic          in_sign = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_frac;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_norm_round_seq #(.MW(MW), .EW(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_frac   (in_frac),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] result_vec();
    return 64'({out_sign, out_exp, out_frac, overflow, underflow});
  endfunction

  task automatic run_op(input string tag, input logic [PW-1:0] f, input logic [EW+1:0] e,
                        input logic s, input logic es, input logic [EW-1:0] ee,
                        input logic [MW-1:0] ef, input logic eo, input logic eu,
                        input int lat, input int hold);
    int edges;
    logic [63:0] expv;
    expv = 64'({es, ee, ef, eo, eu});
    in_frac  = f;
    in_exp   = e;
    in_sign  = s;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      step();
      edges++;
    end
    check({tag, ".latency"}, 64'(edges), 64'(lat));
    check({tag, ".result"}, result_vec(), expv);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_frac  = ~f;
      in_exp   = 10'd3;
      step();
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_result"}, result_vec(), expv);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, ".result_kept"}, result_vec(), expv);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    step();
    step();
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.result", result_vec(), 64'd0);
    rst_n = 1'b1;
    step();

    // tag, in_frac, in_exp, in_sign, exp sign, exp exp, exp frac, ov, un, latency, hold
    run_op("mul_1p5", 48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 8'd128, 23'h100000, 1'b0, 1'b0, 3, 0);
    run_op("tie_even", 48'h4000_0040_0000, 10'd127, 1'b1, 1'b1, 8'd127, 23'h000000, 1'b0, 1'b0, 3, 0);
    run_op("tie_odd", 48'h4000_00C0_0000, 10'd127, 1'b0, 1'b0, 8'd127, 23'h000002, 1'b0, 1'b0, 3, 0);
    run_op("shift_sticky", 48'h8000_0080_0001, 10'd127, 1'b0, 1'b0, 8'd128, 23'h000001, 1'b0, 1'b0, 3, 0);
    run_op("mant_carry", 48'h7FFF_FFC0_0001, 10'd100, 1'b0, 1'b0, 8'd101, 23'h000000, 1'b0, 1'b0, 3, 0);
    run_op("overflow", 48'h8000_0000_0000, 10'd254, 1'b1, 1'b1, 8'hFF, 23'h000000, 1'b1, 1'b0, 3, 0);
    run_op("underflow", 48'h4000_0000_0000, 10'd0, 1'b0, 1'b0, 8'h00, 23'h000000, 1'b0, 1'b1, 3, 0);
    run_op("zero", 48'h0000_0000_0000, 10'd50, 1'b1, 1'b1, 8'h00, 23'h000000, 1'b0, 1'b0, 2, 0);
    run_op("neg_exp_unf", 48'h0000_4000_0000, 10'd10, 1'b0, 1'b0, 8'h00, 23'h000000, 1'b0, 1'b1, 19, 0);
    run_op("lshift_bp", 48'h0000_4000_0000, 10'd127, 1'b1, 1'b1, 8'd111, 23'h000000, 1'b0, 1'b0, 19, 5);

    // Abort a long normalisation with reset; held results must clear and nothing may emerge.
    in_frac  = 48'h0000_4000_0000;
    in_exp   = 10'd127;
    in_sign  = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("abort.in_ready_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.result", result_vec(), 64'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("abort.no_output", 64'(seen), 64'd0);

    run_op("after_abort", 48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 8'd128, 23'h100000, 1'b0, 1'b0, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
